terminal_write_ctrl: RTL and testbench

//  Sequences all writes into the 80x30 text RAM from the UART byte stream. Decodes each

---
 rtl/terminal_pkg.sv | 34 +++
 rtl/terminal_cursor.sv | 70 +++++++
 rtl/terminal_write_ctrl.sv | 165 ++++++++++++++++
 tb/tb_terminal_write_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/terminal_pkg.sv
// Shared constants for the terminal write path: control codes, attribute layout,
// FSM encodings and the cursor command set.
package terminal_pkg;

    localparam logic [7:0] CODE_HOME  = 8'h00;
    localparam logic [7:0] CODE_BS    = 8'h08;
    localparam logic [7:0] CODE_FF    = 8'h0C;
    localparam logic [7:0] CODE_NL    = 8'h13;
    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Attribute byte is 1_fff_0_bbb; the top bit doubles as the "colour command" flag
    localparam int ATTR_FLAG_BIT = 7;
    localparam int ATTR_FG_LSB   = 4;
    localparam int ATTR_BG_LSB   = 0;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_DECODE       = 3'd1;
    localparam logic [2:0] ST_WRITE        = 3'd2;
    localparam logic [2:0] ST_CLEAR_LINE   = 3'd3;
    localparam logic [2:0] ST_CLEAR_SCREEN = 3'd4;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_INC,
        CUR_DEC,
        CUR_NEWLINE,
        CUR_HOME
    } cursor_cmd_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b[ATTR_FLAG_BIT] == 1'b0) && (b >= SPACE_CHAR);
    endfunction

endpackage

// File: rtl/terminal_cursor.sv
// Cursor column/row plus the matching linear TextRAM address, kept in step without
// a multiplier: every move is +1, -1, +WIDTH or back to zero.
module terminal_cursor
    import terminal_pkg::*;
#(
    parameter int WIDTH_CHARS  = 80,
    parameter int HEIGHT_CHARS = 30,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  cursor_cmd_t           cmd,
    output logic [6:0]            col,
    output logic [4:0]            row,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] row_base,
    output logic                  at_last_col,
    output logic                  at_origin
);

    localparam logic [6:0]            LAST_COL = 7'(WIDTH_CHARS - 1);
    localparam logic [4:0]            LAST_ROW = 5'(HEIGHT_CHARS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(WIDTH_CHARS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic do_newline;

    assign at_last_col = (col == LAST_COL);
    assign at_origin   = (col == 7'd0) && (row == 5'd0);
    // Advancing past the last column is a newline, so the caller never has to special-case it
    assign do_newline  = (cmd == CUR_NEWLINE) || ((cmd == CUR_INC) && at_last_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            row_base <= '0;
        end else if (cmd == CUR_HOME) begin
            col      <= '0;
            row      <= '0;
            addr     <= '0;
            row_base <= '0;
        end else if (do_newline) begin
            col <= '0;
            if (row == LAST_ROW) begin
                row      <= '0;
                row_base <= '0;
                addr     <= '0;
            end else begin
                row      <= row + 5'd1;
                row_base <= row_base + ROW_STEP;
                addr     <= row_base + ROW_STEP;
            end
        end else if (cmd == CUR_INC) begin
            col  <= col + 7'd1;
            addr <= addr + ADDR_ONE;
        end else if ((cmd == CUR_DEC) && !at_origin) begin
            addr <= addr - ADDR_ONE;
            if (col != 7'd0) begin
                col <= col - 7'd1;
            end else begin
                col      <= LAST_COL;
                row      <= row - 5'd1;
                row_base <= row_base - ROW_STEP;
            end
        end
    end

endmodule

// File: rtl/terminal_write_ctrl.sv
// Turns the UART byte stream into TextRAM writes: one-deep input buffer, byte decoder,
// and the FSM that runs single-cell writes and multi-cycle line/screen clears.
module terminal_write_ctrl
    import terminal_pkg::*;
#(
    parameter int          WIDTH_CHARS  = 80,
    parameter int          HEIGHT_CHARS = 30,
    parameter int          ADDR_WIDTH   = 12,
    parameter logic [7:0]  DEFAULT_ATTR = 8'hF0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [15:0]           wr_data,
    output logic                  wr_enable,
    output logic [6:0]            cursor_x,
    output logic [4:0]            cursor_y,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [ADDR_WIDTH-1:0] LINE_LAST   = ADDR_WIDTH'(WIDTH_CHARS - 1);
    localparam logic [ADDR_WIDTH-1:0] SCREEN_LAST = ADDR_WIDTH'(WIDTH_CHARS * HEIGHT_CHARS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);

    logic [2:0]            state;
    logic                  pend_valid;
    logic [7:0]            pend_data;
    logic [7:0]            cur_byte;
    logic [7:0]            attr;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic                  consume;
    logic                  clr_done;
    logic                  is_bs;
    cursor_cmd_t           cur_cmd;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] row_base;
    logic                  at_last_col;
    logic                  at_origin;

    assign consume  = (state == ST_IDLE) && pend_valid;
    assign is_bs    = (cur_byte == CODE_BS);
    assign clr_done = (state == ST_CLEAR_SCREEN) ? (clr_idx == SCREEN_LAST) : (clr_idx == LINE_LAST);
    assign busy     = (state != ST_IDLE) || pend_valid;

    terminal_cursor #(
        .WIDTH_CHARS (WIDTH_CHARS),
        .HEIGHT_CHARS(HEIGHT_CHARS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_cursor (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cur_cmd),
        .col        (cursor_x),
        .row        (cursor_y),
        .addr       (cur_addr),
        .row_base   (row_base),
        .at_last_col(at_last_col),
        .at_origin  (at_origin)
    );

    // A byte arriving in the same cycle the buffer drains refills it instead of overrunning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= rx_done && pend_valid && !consume;
            if (consume) begin
                pend_valid <= rx_done;
                if (rx_done) pend_data <= rx_data;
            end else if (rx_done && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_data  <= rx_data;
            end
        end
    end

    always_comb begin
        cur_cmd = CUR_NONE;
        case (state)
            ST_DECODE: begin
                if (!cur_byte[ATTR_FLAG_BIT]) begin
                    if (cur_byte == CODE_HOME)    cur_cmd = CUR_HOME;
                    else if (cur_byte == CODE_BS) cur_cmd = CUR_DEC;
                    else if (cur_byte == CODE_NL) cur_cmd = CUR_NEWLINE;
                end
            end
            ST_WRITE:        if (!is_bs) cur_cmd = CUR_INC;
            ST_CLEAR_SCREEN: if (clr_done) cur_cmd = CUR_HOME;
            default:         cur_cmd = CUR_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_byte <= '0;
            attr     <= DEFAULT_ATTR;
            clr_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        cur_byte <= pend_data;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    clr_idx <= '0;
                    if (cur_byte[ATTR_FLAG_BIT]) begin
                        attr  <= cur_byte;
                        state <= ST_IDLE;
                    end else if (cur_byte == CODE_BS) begin
                        state <= at_origin ? ST_IDLE : ST_WRITE;
                    end else if (cur_byte == CODE_FF) begin
                        state <= ST_CLEAR_SCREEN;
                    end else if (cur_byte == CODE_NL) begin
                        state <= ST_CLEAR_LINE;
                    end else if (is_printable(cur_byte)) begin
                        state <= ST_WRITE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state <= (!is_bs && at_last_col) ? ST_CLEAR_LINE : ST_IDLE;
                end
                ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
                    if (clr_done) state <= ST_IDLE;
                    else          clr_idx <= clr_idx + ADDR_ONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_enable = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state)
            ST_WRITE: begin
                wr_enable = 1'b1;
                wr_addr   = cur_addr;
                wr_data   = {attr, is_bs ? SPACE_CHAR : cur_byte};
            end
            ST_CLEAR_LINE: begin
                wr_enable = 1'b1;
                wr_addr   = row_base + clr_idx;
                wr_data   = {attr, SPACE_CHAR};
            end
            ST_CLEAR_SCREEN: begin
                wr_enable = 1'b1;
                wr_addr   = clr_idx;
                wr_data   = {attr, SPACE_CHAR};
            end
            default: wr_enable = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_terminal_write_ctrl.sv
// Directed bench for terminal_write_ctrl: bytes go straight onto rx_data/rx_done and a
// shadow TextRAM is filled from the write port for checking.
module tb_terminal_write_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_enable;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;
    logic        overrun;

    logic [15:0] mem [0:4095];
    int write_count;
    int overrun_count;
    int test_count;
    int fail_count;

    terminal_write_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_enable(wr_enable),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_enable) begin
            mem[wr_addr] = wr_data;
            write_count++;
        end
        if (overrun) overrun_count++;
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        apply_stimulus(b);
        wait_idle(3000);
    endtask

    task automatic check_cursor(input string tag, input int x, input int y);
        check_output(tag, {20'd0, cursor_y, cursor_x}, {20'd0, 5'(y), 7'(x)});
    endtask

    initial begin
        int wc;
        int oc;
        int spaces;
        write_count   = 0;
        overrun_count = 0;
        test_count    = 0;
        fail_count    = 0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_outputs", {wr_enable, busy, overrun, wr_addr, wr_data}, 32'd0);
        check_cursor("reset_cursor", 0, 0);
        rst_n = 1'b1;

        // 1: plain printable characters in the default attribute
        send("A"); send("B"); send("C");
        check_output("t1_mem0", mem[0], 16'hF041);
        check_output("t1_mem1", mem[1], 16'hF042);
        check_output("t1_mem2", mem[2], 16'hF043);
        check_cursor("t1_cursor", 3, 0);

        // 2: colour change, backspace overwrite
        send(8'b1_100_0_001); send("D"); send("E"); send(8'h08); send("F"); send("G");
        check_output("t2_mem3", mem[3], 16'hC144);
        check_output("t2_mem4", mem[4], 16'hC146);
        check_output("t2_mem5", mem[5], 16'hC147);
        check_cursor("t2_cursor", 6, 0);

        // 3: newline clears the new row before the next character lands
        wc = write_count;
        send(8'h13);
        check_output("t3_nl_writes", write_count - wc, 80);
        check_cursor("t3_nl_cursor", 0, 1);
        send("H");
        spaces = 0;
        for (int i = 81; i < 160; i++) if (mem[i] === 16'hC120) spaces++;
        check_output("t3_spaces", spaces, 79);
        check_output("t3_mem80", mem[80], 16'hC148);
        check_output("t3_mem160", mem[160], 16'hxxxx);
        check_cursor("t3_cursor", 1, 1);

        // 4: backspace across a row boundary, ignored code, home, backspace at origin
        send(8'h08);
        check_output("t4_bs_mem80", mem[80], 16'hC120);
        send(8'h08);
        check_output("t4_bs_mem79", mem[79], 16'hC120);
        check_cursor("t4_bs_wrap_cursor", 79, 0);
        wc = write_count;
        send(8'h01);
        check_cursor("t4_ignored_cursor", 79, 0);
        send(8'h00);
        send(8'h08);
        check_output("t4_no_writes", write_count - wc, 0);
        check_cursor("t4_cursor", 0, 0);

        // 5: printing in the very last cell wraps to the top and clears row 0
        for (int i = 0; i < 29; i++) send(8'h13);
        for (int i = 0; i < 79; i++) send("a");
        check_cursor("t5_setup_cursor", 79, 29);
        wc = write_count;
        send("Z");
        check_output("t5_writes", write_count - wc, 81);
        check_output("t5_mem2399", mem[2399], 16'hC15A);
        check_output("t5_mem2398", mem[2398], 16'hC161);
        check_output("t5_mem0", mem[0], 16'hC120);
        check_output("t5_mem79", mem[79], 16'hC120);
        check_cursor("t5_cursor", 0, 0);

        // 6: clear screen with a colour byte refilling the buffer and a second byte dropped
        wc = write_count;
        oc = overrun_count;
        @(negedge clk); rx_data = 8'h0C; rx_done = 1'b1;
        @(negedge clk); rx_data = 8'h87;
        @(negedge clk); rx_data = "W";
        @(negedge clk); rx_done = 1'b0;
        wait_idle(3000);
        check_output("t6_writes", write_count - wc, 2400);
        check_output("t6_overruns", overrun_count - oc, 1);
        check_output("t6_mem2399", mem[2399], 16'hC120);
        check_cursor("t6_cursor", 0, 0);
        send("Q");
        check_output("t6_new_attr", mem[0], 16'h8751);
        check_cursor("t6_q_cursor", 1, 0);

        // Reset in the middle of a clear aborts it at once
        apply_stimulus(8'h0C);
        repeat (100) @(negedge clk);
        check_output("t6_mid_clear", {31'd0, wr_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_wren", {31'd0, wr_enable}, 32'd0);
        check_output("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_cursor("t6_rst_cursor", 0, 0);
        wc = write_count;
        repeat (5) @(negedge clk);
        check_output("t6_rst_no_writes", write_count - wc, 0);
        rst_n = 1'b1;
        send("R");
        check_output("t6_rst_attr", mem[0], 16'hF052);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
